// File: rtl/clock_entry_pkg.sv
// Shared definitions for the front-panel time entry controller: field indices,
// per-field BCD limits, the commit FSM state type and BCD step helpers.
package clock_entry_pkg;

  localparam logic [1:0] FLD_HOUR = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_SEC  = 2'd2;
  localparam logic [1:0] FLD_MIL  = 2'd3;

  localparam logic [7:0] MAX_HOUR = 8'h23;
  localparam logic [7:0] MAX_MIN  = 8'h59;
  localparam logic [7:0] MAX_SEC  = 8'h59;
  localparam logic [7:0] MAX_MIL  = 8'h99;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_DONE
  } entry_state_e;

  function automatic logic [7:0] fieldMax(input logic [1:0] fld);
    logic [7:0] maxV;
    case (fld)
      FLD_HOUR: maxV = MAX_HOUR;
      FLD_MIN:  maxV = MAX_MIN;
      FLD_SEC:  maxV = MAX_SEC;
      FLD_MIL:  maxV = MAX_MIL;
      default:  maxV = MAX_MIL;
    endcase
    return maxV;
  endfunction

  function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] maxV);
    if (v >= maxV) return 8'h00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  function automatic logic [7:0] bcdDec(input logic [7:0] v, input logic [7:0] maxV);
    if (v == 8'h00) return maxV;
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    return v - 8'h01;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizer, stability counter and press pulse for one active-low key.
// Optional hold-to-repeat when built with AUTO_REPEAT_EN.
module key_debounce
  import clock_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
`ifdef AUTO_REPEAT_EN
  ,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic event_o
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic sync1_q, sync2_q, sync3_q, stable_q, press_q;
  logic [CntW-1:0] cnt_q;

  // sync3_q only exists to spot a change of the synchronized level
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      sync3_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      press_q <= 1'b0;
      if (sync2_q != sync3_q) cnt_q <= '0;
      else if (cnt_q != CntLast) cnt_q <= cnt_q + CntW'(1);
      if (sync2_q == sync3_q && cnt_q == CntLast && sync2_q != stable_q) begin
        stable_q <= sync2_q;
        press_q  <= ~sync2_q;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [31:0] repCnt_q;
  logic        repFirst_q, repPulse_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !REPEAT_EN || stable_q) begin
      repCnt_q   <= '0;
      repFirst_q <= 1'b1;
      repPulse_q <= 1'b0;
    end else begin
      repPulse_q <= 1'b0;
      if (repCnt_q == (repFirst_q ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1))) begin
        repCnt_q   <= '0;
        repFirst_q <= 1'b0;
        repPulse_q <= 1'b1;
      end else begin
        repCnt_q <= repCnt_q + 32'd1;
      end
    end
  end

  assign event_o = press_q | repPulse_q;
`else
  assign event_o = press_q;
`endif

endmodule

// File: rtl/time_entry_ctrl.sv
// Front-panel time/alarm entry: debounced keys edit four BCD fields, commit writes
// them to the clock core via time_in/set_*. Build option: AUTO_REPEAT_EN.
module time_entry_ctrl
  import clock_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int WRITE_HOLD      = 4
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       key_field_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_commit_n,
  input  logic       mode_alarm,
  output logic [7:0] time_in,
  output logic       set_hour,
  output logic       set_minute,
  output logic       set_second,
  output logic       set_mil,
  output logic       set_time,
  output logic       set_alarm,
  output logic [1:0] field_sel,
  output logic [7:0] edit_value,
  output logic       busy,
  output logic       done
);

  localparam int KEY_FIELD  = 0;
  localparam int KEY_UP     = 1;
  localparam int KEY_DOWN   = 2;
  localparam int KEY_COMMIT = 3;
  localparam int HoldW = $clog2(WRITE_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(WRITE_HOLD - 1);

  logic [3:0] keyN, keyEv;
  assign keyN = {key_commit_n, key_down_n, key_up_n, key_field_n};

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_EN      (k == KEY_UP || k == KEY_DOWN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
`endif
    ) u_deb (
      .clk_i  (CLOCK_50),
      .rst_ni (reset_n),
      .key_ni (keyN[k]),
      .event_o(keyEv[k])
    );
  end

  entry_state_e     state_q;
  logic [1:0]       wrFld_q, fieldSel_q, fieldSel_d;
  logic [HoldW-1:0] holdCnt_q;
  logic             alarm_q, setTime_q, setAlarm_q, busy_q, done_q;
  logic [3:0]       setFld_q;
  logic [7:0]       timeIn_q, editValue_q;
  logic [3:0][7:0]  edit_q, edit_d;

  // Commit wins over same-cycle edits; up together with down cancels out
  always_comb begin
    edit_d     = edit_q;
    fieldSel_d = fieldSel_q;
    if (state_q == ST_IDLE && !keyEv[KEY_COMMIT]) begin
      if (keyEv[KEY_FIELD]) fieldSel_d = fieldSel_q + 2'd1;
      if (keyEv[KEY_UP] && !keyEv[KEY_DOWN])
        edit_d[fieldSel_q] = bcdInc(edit_q[fieldSel_q], fieldMax(fieldSel_q));
      else if (keyEv[KEY_DOWN] && !keyEv[KEY_UP])
        edit_d[fieldSel_q] = bcdDec(edit_q[fieldSel_q], fieldMax(fieldSel_q));
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wrFld_q     <= FLD_HOUR;
      holdCnt_q   <= '0;
      alarm_q     <= 1'b0;
      timeIn_q    <= 8'h00;
      setFld_q    <= 4'b0000;
      setTime_q   <= 1'b0;
      setAlarm_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fieldSel_q  <= 2'd0;
      edit_q      <= '0;
      editValue_q <= 8'h00;
    end else begin
      edit_q      <= edit_d;
      fieldSel_q  <= fieldSel_d;
      editValue_q <= edit_d[fieldSel_d];
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (keyEv[KEY_COMMIT]) begin
            state_q  <= ST_SETUP;
            alarm_q  <= mode_alarm;
            wrFld_q  <= FLD_HOUR;
            timeIn_q <= edit_q[FLD_HOUR];
            setFld_q <= 4'b0001;
            busy_q   <= 1'b1;
          end
        end
        ST_SETUP: begin
          state_q    <= ST_STROBE;
          holdCnt_q  <= '0;
          setTime_q  <= ~alarm_q;
          setAlarm_q <= alarm_q;
        end
        ST_STROBE: begin
          if (holdCnt_q == HoldLast) begin
            state_q    <= ST_RELEASE;
            setTime_q  <= 1'b0;
            setAlarm_q <= 1'b0;
          end else begin
            holdCnt_q <= holdCnt_q + HoldW'(1);
          end
        end
        ST_RELEASE: begin
          if (wrFld_q == FLD_MIL) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            setFld_q <= 4'b0000;
            timeIn_q <= 8'h00;
            done_q   <= 1'b1;
          end else begin
            state_q  <= ST_SETUP;
            wrFld_q  <= wrFld_q + 2'd1;
            timeIn_q <= edit_q[wrFld_q + 2'd1];
            setFld_q <= {setFld_q[2:0], 1'b0};
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign time_in    = timeIn_q;
  assign {set_mil, set_second, set_minute, set_hour} = setFld_q;
  assign set_time   = setTime_q;
  assign set_alarm  = setAlarm_q;
  assign field_sel  = fieldSel_q;
  assign edit_value = editValue_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Self-checking bench for time_entry_ctrl with short debounce and write-hold settings.
module tb_time_entry_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 2;
  localparam int KEY_FIELD  = 0;
  localparam int KEY_UP     = 1;
  localparam int KEY_DOWN   = 2;
  localparam int KEY_COMMIT = 3;
  localparam int PRESS_CYC  = DEB + 8;

  typedef struct {
    int         key;
    int         presses;
    logic [1:0] expSel;
    logic [7:0] expVal;
  } vec_t;

  typedef struct {
    logic [3:0] fld;
    logic [7:0] data;
  } writeRec_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n, key_field_n, key_up_n, key_down_n, key_commit_n, mode_alarm;
  logic [7:0] time_in, edit_value;
  logic       set_hour, set_minute, set_second, set_mil, set_time, set_alarm, busy, done;
  logic [1:0] field_sel;

  int assertCount = 0;
  int failCount   = 0;
  vec_t      vecs[18];
  vec_t      vecQ[$];
  writeRec_t writeQ[$];

  time_entry_ctrl #(.DEBOUNCE_CYCLES(DEB), .WRITE_HOLD(HOLD)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .key_field_n (key_field_n),
    .key_up_n    (key_up_n),
    .key_down_n  (key_down_n),
    .key_commit_n(key_commit_n),
    .mode_alarm  (mode_alarm),
    .time_in     (time_in),
    .set_hour    (set_hour),
    .set_minute  (set_minute),
    .set_second  (set_second),
    .set_mil     (set_mil),
    .set_time    (set_time),
    .set_alarm   (set_alarm),
    .field_sel   (field_sel),
    .edit_value  (edit_value),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setKey(input int idx, input logic level);
    case (idx)
      KEY_FIELD: key_field_n  = level;
      KEY_UP:    key_up_n     = level;
      KEY_DOWN:  key_down_n   = level;
      default:   key_commit_n = level;
    endcase
  endtask

  task automatic pressKey(input int idx);
    setKey(idx, 1'b0);
    repeat (PRESS_CYC) @(negedge CLOCK_50);
    setKey(idx, 1'b1);
    repeat (PRESS_CYC) @(negedge CLOCK_50);
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int n = 0; n < v.presses; n++) pressKey(v.key);
    vecQ.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (vecQ.size() == 0) begin
      expectEq($sformatf("vec%0d scoreboard empty", idx), 32'd0, 32'd1);
    end else begin
      e = vecQ.pop_front();
      expectEq($sformatf("vec%0d field_sel", idx), field_sel, e.expSel);
      expectEq($sformatf("vec%0d edit_value", idx), edit_value, e.expVal);
    end
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end
  endtask

  task automatic checkWindow(input int idx, input int len, input int enc, input bit shapeOk);
    expectEq($sformatf("write%0d select length", idx), len, HOLD + 2);
    expectEq($sformatf("write%0d enable length", idx), enc, HOLD);
    expectEq($sformatf("write%0d setup/release shape", idx), shapeOk, 1);
  endtask

  task automatic runCommit(input logic alarmMode, input bit disturb);
    int busyCycles = 0, doneCount = 0, bothHigh = 0, wrongEn = 0, windows = 0;
    int winLen = 0, enCount = 0;
    bit firstEn = 0, lastEn = 0, dataMoved = 0;
    logic [3:0] curFld = 4'b0000;
    logic [3:0] nowFld;
    logic [7:0] winData = 8'h00;
    logic en;
    writeRec_t rec;
    writeQ.push_back('{4'b0001, 8'h12});
    writeQ.push_back('{4'b0010, 8'h34});
    writeQ.push_back('{4'b0100, 8'h56});
    writeQ.push_back('{4'b1000, 8'h78});
    mode_alarm = alarmMode;
    setKey(KEY_COMMIT, 1'b0);
    for (int c = 0; c < 50; c++) begin
      @(negedge CLOCK_50);
      nowFld = {set_mil, set_second, set_minute, set_hour};
      en = alarmMode ? set_alarm : set_time;
      if (set_time && set_alarm) bothHigh++;
      if (alarmMode ? set_time : set_alarm) wrongEn++;
      if (busy) busyCycles++;
      if (done && !busy) doneCount++;
      if (nowFld != curFld) begin
        if (curFld != 4'b0000) checkWindow(windows, winLen, enCount, !firstEn && !lastEn && !dataMoved);
        if (nowFld != 4'b0000) begin
          windows++;
          if (writeQ.size() == 0) begin
            expectEq("unexpected write select", nowFld, 4'b0000);
          end else begin
            rec = writeQ.pop_front();
            expectEq($sformatf("write%0d set_* select", windows), nowFld, rec.fld);
            expectEq($sformatf("write%0d time_in", windows), time_in, rec.data);
          end
          winLen = 0;
          enCount = 0;
          dataMoved = 0;
          winData = time_in;
        end
        curFld = nowFld;
      end
      if (curFld != 4'b0000) begin
        winLen++;
        if (en) enCount++;
        if (winLen == 1) firstEn = en;
        lastEn = en;
        if (time_in !== winData) dataMoved = 1;
      end
      if (c == 12) setKey(KEY_COMMIT, 1'b1);
      if (disturb && c == 4) setKey(KEY_UP, 1'b0);
      if (disturb && c == 10) mode_alarm = ~alarmMode;
      if (disturb && c == 14) setKey(KEY_UP, 1'b1);
    end
    expectEq("busy cycles", busyCycles, 4 * (HOLD + 2));
    expectEq("done pulses", doneCount, 1);
    expectEq("set_time and set_alarm overlap", bothHigh, 0);
    expectEq("wrong write enable cycles", wrongEn, 0);
    expectEq("field writes seen", windows, 4);
    expectEq("writes left in scoreboard", writeQ.size(), 0);
    expectEq("time_in idle", time_in, 8'h00);
    writeQ.delete();
    mode_alarm = 1'b0;
    repeat (PRESS_CYC) @(negedge CLOCK_50);
    expectEq("post-commit field_sel", field_sel, 2'd0);
    expectEq("post-commit edit_value", edit_value, 8'h12);
  endtask

  initial begin
    bit found;
    vecs[0]  = '{KEY_DOWN,   1,  2'd0, 8'h23};
    vecs[1]  = '{KEY_UP,     1,  2'd0, 8'h00};
    vecs[2]  = '{KEY_UP,     10, 2'd0, 8'h10};
    vecs[3]  = '{KEY_FIELD,  1,  2'd1, 8'h00};
    vecs[4]  = '{KEY_DOWN,   1,  2'd1, 8'h59};
    vecs[5]  = '{KEY_FIELD,  1,  2'd2, 8'h00};
    vecs[6]  = '{KEY_DOWN,   5,  2'd2, 8'h56};
    vecs[7]  = '{KEY_FIELD,  2,  2'd0, 8'h10};
    vecs[8]  = '{KEY_UP,     2,  2'd0, 8'h12};
    vecs[9]  = '{KEY_FIELD,  1,  2'd1, 8'h59};
    vecs[10] = '{KEY_DOWN,   25, 2'd1, 8'h34};
    vecs[11] = '{KEY_FIELD,  2,  2'd3, 8'h00};
    vecs[12] = '{KEY_DOWN,   22, 2'd3, 8'h78};
    vecs[13] = '{KEY_FIELD,  1,  2'd0, 8'h12};
    vecs[14] = '{KEY_FIELD,  1,  2'd1, 8'h34};
    vecs[15] = '{KEY_FIELD,  1,  2'd2, 8'h56};
    vecs[16] = '{KEY_FIELD,  1,  2'd3, 8'h78};
    vecs[17] = '{KEY_FIELD,  1,  2'd0, 8'h12};

    reset_n = 1'b0;
    key_field_n = 1'b1;
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    key_commit_n = 1'b1;
    mode_alarm = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    expectEq("reset time_in", time_in, 8'h00);
    expectEq("reset set_*", {set_mil, set_second, set_minute, set_hour}, 4'b0000);
    expectEq("reset set_time/set_alarm", {set_time, set_alarm}, 2'b00);
    expectEq("reset busy/done", {busy, done}, 2'b00);
    expectEq("reset field_sel", field_sel, 2'd0);
    expectEq("reset edit_value", edit_value, 8'h00);

    runVectors(0, 6);

    $display("[TB] bouncing key_up");
    for (int i = 0; i < 15; i++) begin
      key_up_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge CLOCK_50);
    end
    key_up_n = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    key_up_n = 1'b1;
    repeat (PRESS_CYC) @(negedge CLOCK_50);
    expectEq("bounce single increment", edit_value, 8'h01);

    runVectors(6, 14);

    $display("[TB] commit to time");
    runCommit(1'b0, 1'b0);
    $display("[TB] commit to alarm with disturbance");
    runCommit(1'b1, 1'b1);

    runVectors(14, 18);

    key_up_n = 1'b0;
    key_down_n = 1'b0;
    repeat (PRESS_CYC) @(negedge CLOCK_50);
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    repeat (PRESS_CYC) @(negedge CLOCK_50);
    expectEq("up+down cancel", edit_value, 8'h12);

    $display("[TB] reset during second strobe");
    found = 1'b0;
    key_commit_n = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge CLOCK_50);
      if (set_minute && set_time) found = 1'b1;
    end
    expectEq("reached second strobe", found, 1'b1);
    reset_n = 1'b0;
    key_commit_n = 1'b1;
    @(negedge CLOCK_50);
    expectEq("mid-reset set_time/set_alarm", {set_time, set_alarm}, 2'b00);
    expectEq("mid-reset set_*", {set_mil, set_second, set_minute, set_hour}, 4'b0000);
    expectEq("mid-reset busy", busy, 1'b0);
    expectEq("mid-reset edit_value", edit_value, 8'h00);
    expectEq("mid-reset time_in", time_in, 8'h00);
    reset_n = 1'b1;
    repeat (PRESS_CYC * 2) @(negedge CLOCK_50);
    expectEq("after reset stays idle", {busy, set_time, set_alarm}, 3'b000);
    expectEq("after reset field_sel", field_sel, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
